// File: rtl/mac_pkg.sv
// Shared multiplier-accumulator definitions: per-edge command encoding and width helpers.
package mac_pkg;

  typedef enum logic [2:0] {
    CMD_CLR,
    CMD_LD,
    CMD_SHL,
    CMD_SHR,
    CMD_HOLD
  } cmd_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Priority clear > load > left > right; left wins when both shifts are requested
  function automatic cmd_e decode_cmd(input logic init0, input logic ld,
                                      input logic shl, input logic shr);
    if (init0)    return CMD_CLR;
    else if (ld)  return CMD_LD;
    else if (shl) return CMD_SHL;
    else if (shr) return CMD_SHR;
    else          return CMD_HOLD;
  endfunction

endpackage

// File: rtl/shift_reg_n_if.sv
// Command/data bundle for shift_reg_n. The arith select exists only when
// SHIFT_REG_ARITH_EN is defined.
interface shift_reg_n_if #(parameter int N = 8);
  import mac_pkg::*;

  localparam int CNT_W = cnt_width(N);

  logic [N-1:0]     in;
  logic             ld;
  logic             init0;
  logic             shl;
  logic             shr;
  logic             sin;
`ifdef SHIFT_REG_ARITH_EN
  logic             arith;
`endif
  logic [N-1:0]     out;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             done;

  modport master (
`ifdef SHIFT_REG_ARITH_EN
    output arith,
`endif
    output in, ld, init0, shl, shr, sin,
    input  out, carry, cnt, done
  );

  modport slave (
`ifdef SHIFT_REG_ARITH_EN
    input  arith,
`endif
    input  in, ld, init0, shl, shr, sin,
    output out, carry, cnt, done
  );

endinterface

// File: rtl/shift_reg_n_cell.sv
// One bit of shift_reg_n: async-reset flop with hold/clear/load/left/right select.
module shift_cell
  import mac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  cmd_e cmd,
  input  logic load_bit,
  input  logic left_bit,
  input  logic right_bit,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (cmd)
        CMD_CLR:  q <= 1'b0;
        CMD_LD:   q <= load_bit;
        CMD_SHL:  q <= left_bit;
        CMD_SHR:  q <= right_bit;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_n.sv
// N-bit load/clear/shift register with registered shift-out bit and saturating
// shift counter. Defining SHIFT_REG_ARITH_EN adds arithmetic right shift.
module shift_reg_n
  import mac_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  shift_reg_n_if.slave  bus
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

  cmd_e             cmd;
  logic [N-1:0]     q;
  logic             fill;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  assign cmd = decode_cmd(bus.init0, bus.ld, bus.shl, bus.shr);

`ifdef SHIFT_REG_ARITH_EN
  // Sign extension replaces the serial input on arithmetic right shifts
  assign fill = bus.arith ? q[N-1] : bus.sin;
`else
  assign fill = bus.sin;
`endif

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic left_bit;
    logic right_bit;

    if (i == 0) begin : g_lsb
      assign left_bit = bus.sin;
    end else begin : g_lsb_n
      assign left_bit = q[i-1];
    end

    if (i == N - 1) begin : g_msb
      assign right_bit = fill;
    end else begin : g_msb_n
      assign right_bit = q[i+1];
    end

    shift_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .cmd       (cmd),
      .load_bit  (bus.in[i]),
      .left_bit  (left_bit),
      .right_bit (right_bit),
      .q         (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      case (cmd)
        CMD_CLR, CMD_LD: carry_q <= 1'b0;
        CMD_SHL:         carry_q <= q[N-1];
        CMD_SHR:         carry_q <= q[0];
        default:         carry_q <= carry_q;
      endcase
    end
  end

  // Counter saturates at N so done stays high while the operand keeps shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      case (cmd)
        CMD_CLR, CMD_LD:  cnt_q <= '0;
        CMD_SHL, CMD_SHR: cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        default:          cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.out   = q;
  assign bus.carry = carry_q;
  assign bus.cnt   = cnt_q;
  assign bus.done  = (cnt_q == CNT_MAX);

endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised N-bit register for the multiplier-accumulator datapath. Adds to plain load/clear behaviour: serial left and right shifting, a registered shifted-out bit, and a saturating shift counter with a `done` flag. The multiplier controller uses it for shift-add operands and to detect when all N bits are consumed without an external counter.

## Interface
- `N`, default 8: data width in bits; legal values N ≥ 2.
- `CNT_W`, default $clog2(N+1): counter width; derived, never overridden.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  N  parallel load data.
- `ld`  in  1  parallel load.
- `init0`  in  1  synchronous clear.
- `shl`  in  1  shift left one bit.
- `shr`  in  1  shift right one bit.
- `sin`  in  1  serial input bit for either shift direction.
- `arith`  in  1  arithmetic right shift select; present only with `SHIFT_REG_ARITH_EN`.
- `out`  out  N  register contents.
- `carry`  out  1  last bit shifted out, registered.
- `cnt`  out  CNT_W  shifts since last clear/load, saturating at N.
- `done`  out  1  high when `cnt == N`.

## Operation
- Command priority per edge: `init0` > `ld` > `shl` > `shr` > hold.
- init0: out ← 0, carry ← 0, cnt ← 0.
- ld: out ← in, carry ← 0, cnt ← 0.
- shl: out ← {out[N-2:0], sin}; carry ← out[N-1]; cnt ← min(cnt+1, N).
- shr: out ← {fill, out[N-1:1]}; carry ← out[0]; cnt ← min(cnt+1, N). `fill` is `sin`, except as given under Configuration.
- hold: all state unchanged.
- `shl` and `shr` together: left shift only.
- Shifts after `done`: `out` and `carry` keep shifting normally; `cnt` stays at N; `done` stays high.
- `done` decodes combinationally from registered `cnt`. No other combinational input-to-output paths exist.
- No state machine beyond the counter. Counter states run 0..N; transitions occur only on shift, clear or load.

## Timing
- Reset: `rst` high forces out = 0, carry = 0, cnt = 0, done = 0 immediately, independent of `clk`. This holds mid-shift-sequence and while any command is asserted.
- Deassertion of `rst`: the first rising edge with `rst` low executes the command present at that edge.
- Latency: one cycle. A command sampled at edge k is visible on all outputs after edge k.
- `done` rises in the same cycle `cnt` reaches N, i.e. after the N-th shift edge.
- Commands are level-sampled each edge; there is no handshake. Holding `shl` for M cycles performs M shifts.

## Configuration
- `SHIFT_REG_ARITH_EN` defined:
  - Port `arith` exists.
  - Right shift with arith = 1 uses fill = out[N-1] (sign extension) and ignores `sin`.
  - With arith = 0, fill = `sin`.
- `SHIFT_REG_ARITH_EN` undefined:
  - Port `arith` is absent.
  - Right shift always uses fill = `sin`.

## Structure
- Shared package `mac_pkg`:
  - command-priority encoding (enum CMD_CLR, CMD_LD, CMD_SHL, CMD_SHR, CMD_HOLD);
  - counter-width helper function.
- One sub-module, `shift_cell`: a 1-bit flip-flop with async reset and a mux selecting hold/clear/load/left-neighbour/right-neighbour. It is instantiated N times in a generate loop.
- Counter, `carry` and `done` logic live in the top module.

## Test plan
- Reset: N=4, load 1010 then assert `rst` mid-cycle → out=0000, carry=0, cnt=0, done=0 before the next edge.
- Load: ld=1, in=1010 for one edge → out=1010, cnt=0. Then ld=0, in=1111 → out holds 1010.
- Shift left: from 1010, shl=1, sin=1 for 4 edges → out 0101/1011/0111/1111, carry 1/0/1/0, cnt 1/2/3/4, done=1 after edge 4. A 5th shift → out=1111, carry=1, cnt=4.
- Priority: init0=1, ld=1, in=1100 → out=0000, cnt=0. Then shl=shr=1, sin=0 on 0110 → out=1100 (left shift), carry=0.
- Right shift, macro defined: from 1100, shr=1, arith=1, sin=0 for 2 edges → out 1110/1111, carry 0/0.
- Right shift, macro undefined: same stimulus → out 0110/0011, carry 0/0, cnt 2.
